ucie_ctl_sb_arbiter: RTL
========================

UCIE_CTL_SB_ARBITER -- requirements
Module: ucie_ctl_sb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3: number of sideband requesters (CNTL FSM, logging, retrain/CSR).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16: maximum cycles to wait for sideband completion.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock (FDI lclk domain).
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_req, input, NUM_REQ bits: per-requester level request, held until acked.
REQ-006 The block SHALL have port i_req_decode, input, NUM_REQ*5 bits: packed sb decode per requester; requester k occupies bits [5k+4:5k].
REQ-007 The block SHALL have port i_req_data, input, NUM_REQ*32 bits: packed adv-cap payload; requester k occupies bits [32k+31:32k].
REQ-008 The block SHALL have port i_sb_busy_flag, input, 1 bit: sideband module busy.
REQ-009 The block SHALL have port o_ack, output, NUM_REQ bits: one-hot, one-cycle pulse marking the requester being issued.
REQ-010 The block SHALL have port o_rdi_lp_sb_decode, output, 5 bits: decode of the issued message.
REQ-011 The block SHALL have port o_rdi_lp_adv_cap_val, output, 32 bits: payload of the issued message.
REQ-012 The block SHALL have port o_valid_lp_sb, output, 1 bit: one-cycle issue strobe.
REQ-013 The block SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse on completion timeout.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-016 In IDLE with any i_req bit set and i_sb_busy_flag=0, the block SHALL select one requester round-robin, register its decode and data, and move to ISSUE.
REQ-017 Round-robin search SHALL start at ptr and wrap modulo NUM_REQ; after a grant to requester k, ptr SHALL become (k+1) mod NUM_REQ.
REQ-018 In IDLE with i_sb_busy_flag=1, the block SHALL NOT grant, even if requests are pending.
REQ-019 A request deasserted before it is selected SHALL be ignored; the block SHALL NOT latch or remember it.
REQ-020 In ISSUE (exactly one cycle), o_valid_lp_sb and the o_ack bit of the selected requester SHALL both be 1; the next state SHALL be WAIT_START.
REQ-021 Latency from a qualifying request in IDLE at cycle N to o_valid_lp_sb SHALL be exactly one cycle (strobe at N+1).
REQ-022 In WAIT_START, starting the cycle after ISSUE, i_sb_busy_flag=1 SHALL move the FSM to WAIT_DONE.
REQ-023 In WAIT_DONE, i_sb_busy_flag=0 SHALL move the FSM to IDLE; the earliest next grant is the following cycle.
REQ-024 A timeout counter SHALL clear on entry to WAIT_START and increment every cycle in WAIT_START and WAIT_DONE.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1 without completion, o_timeout SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-026 If completion and timeout occur in the same cycle, completion SHALL take precedence and o_timeout SHALL stay 0.
REQ-027 The timeout counter width SHALL be clog2(TIMEOUT_CYCLES) bits; it SHALL saturate and never wrap.
REQ-028 o_rdi_lp_sb_decode and o_rdi_lp_adv_cap_val SHALL hold the last issued value until the next grant.
REQ-029 o_ack SHALL be 0 in every state except ISSUE.

Reset
REQ-030 While i_rst_n=0, asynchronously: state=IDLE, ptr=0, counter=0, all outputs=0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction with no ack or timeout pulse; the first grant after release SHALL start from requester 0.

Structure
REQ-032 Package ucie_ctl_pkg SHALL hold the state enum, SB_DECODE_W=5 and SB_DATA_W=32.
REQ-033 The round-robin selector SHALL be one sub-module, ucie_ctl_rr_arb (inputs: req, ptr; output: one-hot grant).

Verification
REQ-034 Single request: i_req=001, decode=5'h0A, data=32'h1234_5678, busy=0 -> at N+1, valid=1, ack=001, outputs 0A/12345678; busy 1 then 0 -> IDLE.
REQ-035 Contention: i_req=111 held, each transaction completes -> acks in order 001, 010, 100, 001.
REQ-036 Busy gating: busy=1 in IDLE with i_req=010 -> no valid; busy drops at cycle M -> valid at M+1.
REQ-037 Timeout: issue, busy never rises -> o_timeout pulses exactly 16 cycles after ISSUE (counter reaches 15), then FSM in IDLE.
REQ-038 Reset mid-WAIT_DONE -> all outputs 0 immediately; after release, i_req=110 -> ack=010.
REQ-039 Race: busy falls on the same cycle the counter reaches 15 -> o_timeout=0 and FSM returns to IDLE.

Source files
------------

// File: rtl/ucie_ctl_pkg.sv
// ucie_ctl_pkg: shared sideband arbiter types and widths (state enum, SB_DECODE_W, SB_DATA_W)
package ucie_ctl_pkg;
  localparam int SB_DECODE_W = 5;
  localparam int SB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
endpackage

// File: rtl/ucie_ctl_rr_arb.sv
// ucie_ctl_rr_arb: round-robin one-hot grant; ports req (requests), ptr (search start), grant (one-hot)
module ucie_ctl_rr_arb #(
  parameter int NUM_REQ = 3,
  parameter int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant
);
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_REQ]) grant = NUM_REQ'(1) << ((int'(ptr) + i) % NUM_REQ);
  end
endmodule

// File: rtl/ucie_ctl_sb_arbiter.sv
// ucie_ctl_sb_arbiter: RR sideband arbiter with completion timeout; in i_clk,i_rst_n,i_req,i_req_decode,i_req_data,i_sb_busy_flag; out o_ack,o_rdi_lp_sb_decode,o_rdi_lp_adv_cap_val,o_valid_lp_sb,o_busy,o_timeout
module ucie_ctl_sb_arbiter
  import ucie_ctl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*SB_DECODE_W-1:0] i_req_decode,
  input  logic [NUM_REQ*SB_DATA_W-1:0] i_req_data,
  input  logic                         i_sb_busy_flag,
  output logic [NUM_REQ-1:0]           o_ack,
  output logic [SB_DECODE_W-1:0]       o_rdi_lp_sb_decode,
  output logic [SB_DATA_W-1:0]         o_rdi_lp_adv_cap_val,
  output logic                         o_valid_lp_sb,
  output logic                         o_busy,
  output logic                         o_timeout
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 2);
  state_t state;
  logic [PW-1:0] ptr, k, ptr_nxt;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] grant;
  ucie_ctl_rr_arb #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (.req(i_req), .ptr(ptr), .grant(grant));
  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_REQ; i++) if (grant[i]) k = PW'(i);
  end
  assign ptr_nxt = (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      o_ack <= '0;
      o_valid_lp_sb <= 1'b0;
      o_timeout <= 1'b0;
      o_rdi_lp_sb_decode <= '0;
      o_rdi_lp_adv_cap_val <= '0;
    end else begin
      o_ack <= '0;
      o_valid_lp_sb <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: if (|i_req && !i_sb_busy_flag) begin
          state <= ISSUE;
          o_ack <= grant;
          o_valid_lp_sb <= 1'b1;
          o_rdi_lp_sb_decode <= i_req_decode[int'(k)*SB_DECODE_W +: SB_DECODE_W];
          o_rdi_lp_adv_cap_val <= i_req_data[int'(k)*SB_DATA_W +: SB_DATA_W];
          ptr <= ptr_nxt;
        end
        ISSUE: begin
          state <= WAIT_START;
          cnt <= '0;
        end
        default: begin
          cnt <= (&cnt) ? cnt : cnt + 1'b1;
          if (state == WAIT_DONE && !i_sb_busy_flag) state <= IDLE;
          else if (cnt == T_LAST) begin
            state <= IDLE;
            o_timeout <= 1'b1;
          end else if (state == WAIT_START && i_sb_busy_flag) state <= WAIT_DONE;
        end
      endcase
    end
  end
endmodule
